// File: rtl/four_bit_cpu_if.sv
`timescale 1ns/1ps
// four_bit_cpu_if: program-ROM instruction bus plus the IN/OUT ports of the 4-bit CPU
interface four_bit_cpu_if;
  logic [7:0] order;
  logic [3:0] IN;
  logic [3:0] OUT;
  logic [3:0] CNT;
  modport master (output order, IN, input OUT, CNT);
  modport slave (input order, IN, output OUT, CNT);
endinterface

// File: rtl/four_bit_cpu.sv
`timescale 1ns/1ps
// four_bit_cpu: single-cycle TD4-class accumulator CPU, one instruction retired per rising edge
module four_bit_cpu (
  input  logic           CLK,
  input  logic           RST,
  four_bit_cpu_if.slave  bus
);
  logic [3:0] r_a, r_b, r_out, r_pc;
  logic       r_c;
  logic [3:0] w_op, w_im, w_src, w_add;
  logic [4:0] w_sum;
  logic       w_ld_a, w_ld_b, w_ld_out, w_jmp;
  assign w_op  = bus.order[7:4];
  assign w_im  = bus.order[3:0];
  assign w_sum = {1'b0, w_src} + {1'b0, w_add};
  // every opcode goes through the adder, so non-ADD ops naturally produce carry 0
  always_comb begin
    w_src    = 4'd0;
    w_add    = 4'd0;
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_ld_out = 1'b0;
    w_jmp    = 1'b0;
    case (w_op)
      4'b0000: begin w_src = r_a;    w_add = w_im; w_ld_a = 1'b1; end
      4'b0001: begin w_src = r_b;    w_ld_a = 1'b1; end
      4'b0010: begin w_src = bus.IN; w_ld_a = 1'b1; end
      4'b0011: begin w_add = w_im;   w_ld_a = 1'b1; end
      4'b0100: begin w_src = r_a;    w_ld_b = 1'b1; end
      4'b0101: begin w_src = r_b;    w_add = w_im; w_ld_b = 1'b1; end
      4'b0110: begin w_src = bus.IN; w_ld_b = 1'b1; end
      4'b0111: begin w_add = w_im;   w_ld_b = 1'b1; end
      4'b1001: begin w_src = r_b;    w_ld_out = 1'b1; end
      4'b1011: begin w_add = w_im;   w_ld_out = 1'b1; end
      4'b1110: w_jmp = ~r_c;
      4'b1111: w_jmp = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_a   <= 4'd0;
      r_b   <= 4'd0;
      r_c   <= 1'b0;
      r_out <= 4'd0;
      r_pc  <= 4'd0;
    end else begin
      r_c  <= w_sum[4];
      r_pc <= w_jmp ? w_im : r_pc + 4'd1;
      if (w_ld_a) r_a <= w_sum[3:0];
      if (w_ld_b) r_b <= w_sum[3:0];
      if (w_ld_out) r_out <= w_sum[3:0];
    end
  assign bus.OUT = r_out;
  assign bus.CNT = r_pc;
endmodule

// File: tb/tb_four_bit_cpu.sv
`timescale 1ns/1ps
// tb_four_bit_cpu: directed instruction sequences with hand-computed CNT/OUT expectations
module tb_four_bit_cpu;
  logic CLK, RST;
  int vec = 0;
  int errs = 0;
  four_bit_cpu_if bus ();
  four_bit_cpu dut (.CLK(CLK), .RST(RST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] o);
    bus.order = o;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RST = 1'b0;
    bus.IN = 4'd0;
    bus.order = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(8'($urandom));
      chk("rst_cnt", bus.CNT, 4'd0);
    end
    chk("rst_out", bus.OUT, 4'd0);
    RST = 1'b1;
    step(8'hB1); chk("out1_cnt1", bus.CNT, 4'd1); chk("out1_out", bus.OUT, 4'd1);
    step(8'hB1); chk("out1_cnt2", bus.CNT, 4'd2);
    step(8'hB1); chk("out1_cnt3", bus.CNT, 4'd3);
    step(8'h39);
    step(8'h0A);
    step(8'hE0); chk("jnc_not_taken", bus.CNT, 4'd6);
    step(8'hE2); chk("jnc_c_cleared", bus.CNT, 4'd2);
    step(8'h40);
    step(8'h90); chk("add_a_wrap", bus.OUT, 4'd3);
    chk("seq_cnt", bus.CNT, 4'd4);
    step(8'h73);
    step(8'h52);
    step(8'hE7); chk("jnc_taken", bus.CNT, 4'd7);
    step(8'h90); chk("out_b5", bus.OUT, 4'd5);
    step(8'h5F);
    step(8'hE0); chk("add_b_carry", bus.CNT, 4'd10);
    step(8'h90); chk("add_b_wrap", bus.OUT, 4'd4);
    step(8'h5C);
    step(8'h80);
    step(8'hE5); chk("nop_clears_c", bus.CNT, 4'd5);
    chk("out_hold", bus.OUT, 4'd4);
    step(8'h90); chk("add_b_zero", bus.OUT, 4'd0);
    step(8'hFF); chk("jmp15", bus.CNT, 4'd15);
    step(8'hA0); chk("pc_wrap", bus.CNT, 4'd0);
    bus.IN = 4'hA;
    step(8'h20);
    bus.IN = 4'h0;
    step(8'h40);
    step(8'h90); chk("in_a", bus.OUT, 4'hA);
    bus.IN = 4'h6;
    step(8'h60);
    bus.IN = 4'h0;
    step(8'h90); chk("in_b", bus.OUT, 4'h6);
    step(8'h10);
    step(8'h70);
    step(8'h40);
    step(8'h90); chk("mov_a_b", bus.OUT, 4'h6);
    step(8'h3F);
    step(8'h01);
    step(8'h3C);
    step(8'hE9); chk("mov_clears_c", bus.CNT, 4'd9);
    step(8'hBE); chk("out_im", bus.OUT, 4'hE);
    #3;
    RST = 1'b0;
    #1;
    chk("async_cnt", bus.CNT, 4'd0);
    chk("async_out", bus.OUT, 4'd0);
    step(8'hB5); chk("rst_hold_cnt", bus.CNT, 4'd0);
    chk("rst_hold_out", bus.OUT, 4'd0);
    RST = 1'b1;
    step(8'hB7); chk("restart_cnt", bus.CNT, 4'd1); chk("restart_out", bus.OUT, 4'd7);
    step(8'h40);
    step(8'h90); chk("rst_clears_a", bus.OUT, 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
